// File: rtl/sr_bank_arbiter_if.sv
// Requester-side bus for sr_bank_arbiter. The requesters drive it through the
// master modport, and the arbiter owns the slave modport.
interface sr_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] set_mask;
  logic [NREQ*WIDTH-1:0] clr_mask;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic                  busy;
  logic                  conflict;
  logic [7:0]            conflict_cnt;

  modport master (
    output req, set_mask, clr_mask,
    input  gnt, q, qbar, busy, conflict, conflict_cnt
  );

  modport slave (
    input  req, set_mask, clr_mask,
    output gnt, q, qbar, busy, conflict, conflict_cnt
  );
endinterface

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that applies one winner's set/clear masks per clock to a shared SR bank.
// Optional saturating conflict counter: define SR_BANK_CONFLICT_CNT_EN.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_bank_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr, win_idx, nxt_ptr;
  logic             win_vld;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] q, q_nxt, s_win, r_win;
  logic             busy, conflict, conf_nxt;
  int               idx;

  // Scan from the highest offset down, so the lowest offset that matches wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  assign s_win    = bus.set_mask[int'(win_idx)*WIDTH +: WIDTH];
  assign r_win    = bus.clr_mask[int'(win_idx)*WIDTH +: WIDTH];
  assign conf_nxt = win_vld & (|(s_win & r_win));
  assign nxt_ptr  = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  // When S and R are both set, the bit holds. Only an exclusive S or an exclusive R moves it.
  for (genvar b = 0; b < WIDTH; b++) begin : g_sr
    assign q_nxt[b] = (s_win[b] & ~r_win[b]) | (q[b] & ~(r_win[b] & ~s_win[b]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      q        <= '0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else if (win_vld) begin
      state    <= GRANT;
      rr_ptr   <= nxt_ptr;
      gnt      <= NREQ'(1) << win_idx;
      q        <= q_nxt;
      busy     <= 1'b1;
      conflict <= conf_nxt;
    end else begin
      state    <= IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end
  end

`ifdef SR_BANK_CONFLICT_CNT_EN
  logic [7:0] cnt;
  // Count off the next-state pulse, so the count moves in the same cycle that conflict shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 8'd0;
    else if (conf_nxt && cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end
  assign bus.conflict_cnt = cnt;
`else
  assign bus.conflict_cnt = 8'd0;
`endif

  assign bus.gnt      = gnt;
  assign bus.q        = q;
  assign bus.qbar     = ~q;
  assign bus.busy     = busy;
  assign bus.conflict = conflict;
endmodule
